// File: rtl/ula_arb.sv
// Round-robin arbiter/sequencer sharing one external W-bit ALU between two requesters.
// Accepts one operation at a time, runs it for one EXEC cycle and pulses the result back to its owner.
module ula_arb #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp_s,
  output logic         rsp_z,
  output logic         busy,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_s
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   prio;
  logic   owner;
  logic   gnt_valid;
  logic   gnt;

  // Grant decision; readies are held low while reset is asserted.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = 1'b0;
    if (rst_n && state == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_valid = 1'b1;
        gnt       = prio;
      end else if (req0_valid) begin
        gnt_valid = 1'b1;
        gnt       = 1'b0;
      end else if (req1_valid) begin
        gnt_valid = 1'b1;
        gnt       = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_valid & ~gnt;
  assign req1_ready = gnt_valid & gnt;

  // Sequencer: operand capture, result capture and response pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      busy       <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_s      <= '0;
      rsp_z      <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            state  <= EXEC;
            owner  <= gnt;
            busy   <= 1'b1;
            alu_op <= gnt ? req1_op : req0_op;
            alu_a  <= gnt ? req1_a  : req0_a;
            alu_b  <= gnt ? req1_b  : req0_b;
          end
        end
        EXEC: begin
          state      <= RESP;
          rsp_s      <= alu_s;
          rsp_z      <= (alu_s == '0);
          rsp0_valid <= ~owner;
          rsp1_valid <= owner;
        end
        RESP: begin
          state      <= IDLE;
          busy       <= 1'b0;
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          prio       <= ~owner;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arb.sv
// Self-checking bench for ula_arb: directed handshake sequences, an opcode table,
// and a randomized run against a transaction-level model with its own ALU.
module tb_ula_arb;

  localparam int unsigned W = 4;
  localparam int M = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp_s;
  logic         rsp_z;
  logic         busy;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_s;

  int n_run  = 0;
  int n_fail = 0;

  ula_arb #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_s(rsp_s), .rsp_z(rsp_z), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU in plain integer arithmetic.
  function automatic int alu_ref(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % M;
      1: return (a - b + M) % M;
      2: return (b >= int'(W)) ? 0 : (a * (1 << b)) % M;
      3: return (b >= int'(W)) ? 0 : a / (1 << b);
      4: return a & b;
      5: return a | b;
      6: return a ^ b;
      default: return (M - 1) - a;
    endcase
  endfunction

  always_comb alu_s = W'(alu_ref(int'(alu_op), int'(alu_a), int'(alu_b)));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation from IDLE, checking every cycle of its latency.
  task automatic do_op(input logic who, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] s, input logic z,
                       input string nm);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (who) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    chk({nm, " ready0"}, 32'(req0_ready), 32'(!who));
    chk({nm, " ready1"}, 32'(req1_ready), 32'(who));
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk({nm, " exec busy"}, 32'(busy), 32'd1);
    chk({nm, " exec rsp"}, 32'({rsp0_valid, rsp1_valid}), 32'd0);
    chk({nm, " alu_op"}, 32'(alu_op), 32'(op));
    chk({nm, " alu_a"}, 32'(alu_a), 32'(a));
    chk({nm, " alu_b"}, 32'(alu_b), 32'(b));
    step();
    chk({nm, " resp busy"}, 32'(busy), 32'd1);
    chk({nm, " rsp0"}, 32'(rsp0_valid), 32'(!who));
    chk({nm, " rsp1"}, 32'(rsp1_valid), 32'(who));
    chk({nm, " rsp_s"}, 32'(rsp_s), 32'(s));
    chk({nm, " rsp_z"}, 32'(rsp_z), 32'(z));
    step();
    chk({nm, " idle busy"}, 32'(busy), 32'd0);
    chk({nm, " idle rsp"}, 32'({rsp0_valid, rsp1_valid}), 32'd0);
    chk({nm, " hold s"}, 32'(rsp_s), 32'(s));
  endtask

  typedef struct {
    logic         who;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         z;
  } vec_t;

  typedef struct {
    int cyc;
    int who;
    int s;
  } pend_t;

  vec_t tbl[14];

  initial begin
    pend_t        pq[$];
    logic         vv[2];
    logic         acc[2];
    logic [2:0]   rop[2];
    logic [W-1:0] ra[2], rb[2];
    int           next_free, prio_m, last_s, g;
    bit           idle, g_ok;

    tbl[0]  = '{1'b0, 3'd0, 4'h5, 4'h3, 4'h8, 1'b0};
    tbl[1]  = '{1'b1, 3'd1, 4'h3, 4'h5, 4'hE, 1'b0};
    tbl[2]  = '{1'b0, 3'd2, 4'h1, 4'h2, 4'h4, 1'b0};
    tbl[3]  = '{1'b1, 3'd3, 4'h8, 4'h3, 4'h1, 1'b0};
    tbl[4]  = '{1'b0, 3'd2, 4'h3, 4'h4, 4'h0, 1'b1};
    tbl[5]  = '{1'b1, 3'd3, 4'hF, 4'h5, 4'h0, 1'b1};
    tbl[6]  = '{1'b0, 3'd4, 4'hC, 4'hA, 4'h8, 1'b0};
    tbl[7]  = '{1'b1, 3'd5, 4'hC, 4'hA, 4'hE, 1'b0};
    tbl[8]  = '{1'b0, 3'd6, 4'h6, 4'h6, 4'h0, 1'b1};
    tbl[9]  = '{1'b1, 3'd7, 4'hF, 4'h0, 4'h0, 1'b1};
    tbl[10] = '{1'b0, 3'd0, 4'hF, 4'h1, 4'h0, 1'b1};
    tbl[11] = '{1'b1, 3'd7, 4'h5, 4'h3, 4'hA, 1'b0};
    tbl[12] = '{1'b0, 3'd2, 4'h9, 4'h1, 4'h2, 1'b0};
    tbl[13] = '{1'b1, 3'd1, 4'h0, 4'h1, 4'hF, 1'b0};

    // Reset with both requesters already presenting the contention pair.
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 4'h3; req0_b = 4'h5;
    req1_valid = 1'b1; req1_op = 3'd4; req1_a = 4'hC; req1_b = 4'hA;
    repeat (3) step();
    chk("rst ready0", 32'(req0_ready), 32'd0);
    chk("rst ready1", 32'(req1_ready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    chk("rst rsp_s", 32'(rsp_s), 32'd0);
    chk("rst rsp_z", 32'(rsp_z), 32'd1);
    chk("rst alu", 32'({alu_op, alu_a, alu_b}), 32'd0);

    // Contention: req0 first, then req1 wins over req0's fresh request.
    rst_n = 1'b1;
    #1;
    chk("cont ready0", 32'(req0_ready), 32'd1);
    chk("cont ready1", 32'(req1_ready), 32'd0);
    step();
    req0_op = 3'd5; req0_a = 4'h1; req0_b = 4'h2;
    #1;
    chk("cont exec busy", 32'(busy), 32'd1);
    chk("cont exec ready", 32'({req0_ready, req1_ready}), 32'd0);
    step();
    chk("cont resp0", 32'({rsp0_valid, rsp1_valid}), 32'b10);
    chk("cont resp0 s", 32'(rsp_s), 32'hE);
    chk("cont resp0 z", 32'(rsp_z), 32'd0);
    chk("cont resp ready", 32'({req0_ready, req1_ready}), 32'd0);
    step();
    chk("fair ready", 32'({req0_ready, req1_ready}), 32'b01);
    chk("fair busy", 32'(busy), 32'd0);
    step();
    req1_valid = 1'b0;
    #1;
    chk("cont exec1 alu_op", 32'(alu_op), 32'd4);
    step();
    chk("cont resp1", 32'({rsp0_valid, rsp1_valid}), 32'b01);
    chk("cont resp1 s", 32'(rsp_s), 32'h8);
    step();
    chk("alt ready", 32'({req0_ready, req1_ready}), 32'b10);
    step();
    req0_valid = 1'b0;
    #1;
    step();
    chk("alt resp0", 32'({rsp0_valid, rsp1_valid}), 32'b10);
    chk("alt resp0 s", 32'(rsp_s), 32'h3);
    step();

    // Back-to-back streaming from req1.
    req1_valid = 1'b1; req1_op = 3'd2; req1_a = 4'h1; req1_b = 4'h2;
    #1;
    chk("strm ready1", 32'(req1_ready), 32'd1);
    step();
    req1_op = 3'd7; req1_a = 4'hF; req1_b = 4'h0;
    #1;
    chk("strm exec rsp", 32'(rsp1_valid), 32'd0);
    step();
    chk("strm p1", 32'(rsp1_valid), 32'd1);
    chk("strm p1 s", 32'(rsp_s), 32'h4);
    step();
    chk("strm gap", 32'(rsp1_valid), 32'd0);
    chk("strm ready again", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    #1;
    chk("strm gap2", 32'(rsp1_valid), 32'd0);
    step();
    chk("strm p2", 32'(rsp1_valid), 32'd1);
    chk("strm p2 s", 32'(rsp_s), 32'h0);
    chk("strm p2 z", 32'(rsp_z), 32'd1);
    step();

    // Opcode table.
    for (int i = 0; i < 14; i++)
      do_op(tbl[i].who, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].z, $sformatf("tbl%0d", i));

    // Reset during EXEC: pointer left at 1 beforehand, must come back to 0.
    do_op(1'b0, 3'd0, 4'h2, 4'h3, 4'h5, 1'b0, "pre");
    req0_valid = 1'b1; req0_op = 3'd6; req0_a = 4'h6; req0_b = 4'h6;
    #1;
    step();
    req0_valid = 1'b0;
    #1;
    chk("abort exec busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort rsp_s", 32'(rsp_s), 32'd0);
    chk("abort rsp_z", 32'(rsp_z), 32'd1);
    step();
    chk("abort no pulse a", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    step();
    chk("abort no pulse b", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'h1; req0_b = 4'h1;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 4'h2; req1_b = 4'h2;
    #1;
    chk("abort prio ready", 32'({req0_ready, req1_ready}), 32'b10);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    step();
    chk("abort after rsp", 32'({rsp0_valid, rsp1_valid}), 32'b10);
    chk("abort after s", 32'(rsp_s), 32'h2);
    step();

    // Full opcode sweep with random operands.
    for (int op = 0; op < 8; op++) begin
      logic [W-1:0] a, b, s;
      a = W'($urandom_range(0, M - 1));
      b = W'($urandom_range(0, M - 1));
      s = W'(alu_ref(op, int'(a), int'(b)));
      do_op(1'(op % 2), 3'(op), a, b, s, (s == 0), $sformatf("sweep%0d", op));
    end

    // Randomized traffic against a transaction-level model.
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    rst_n = 1'b1;
    next_free = 0; prio_m = 0; last_s = 0;
    for (int r = 0; r < 2; r++) begin
      vv[r] = 1'b0; acc[r] = 1'b0; rop[r] = '0; ra[r] = '0; rb[r] = '0;
    end
    for (int c = 0; c < 800; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!vv[r] || acc[r]) begin
          vv[r]  = ($urandom_range(0, 3) != 0);
          rop[r] = 3'($urandom_range(0, 7));
          ra[r]  = W'($urandom_range(0, M - 1));
          rb[r]  = W'($urandom_range(0, M - 1));
        end else if ($urandom_range(0, 9) == 0) begin
          vv[r] = 1'b0;
        end
      end
      req0_valid = vv[0]; req0_op = rop[0]; req0_a = ra[0]; req0_b = rb[0];
      req1_valid = vv[1]; req1_op = rop[1]; req1_a = ra[1]; req1_b = rb[1];
      #1;
      idle = (c >= next_free);
      g_ok = idle && (vv[0] || vv[1]);
      g    = (vv[0] && vv[1]) ? prio_m : (vv[1] ? 1 : 0);
      chk("rnd ready0", 32'(req0_ready), 32'(g_ok && g == 0));
      chk("rnd ready1", 32'(req1_ready), 32'(g_ok && g == 1));
      chk("rnd busy", 32'(busy), 32'(!idle));
      if (pq.size() > 0 && pq[0].cyc == c) begin
        last_s = pq[0].s;
        chk("rnd rsp0", 32'(rsp0_valid), 32'(pq[0].who == 0));
        chk("rnd rsp1", 32'(rsp1_valid), 32'(pq[0].who == 1));
        void'(pq.pop_front());
      end else begin
        chk("rnd no rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      end
      chk("rnd rsp_s", 32'(rsp_s), 32'(last_s));
      chk("rnd rsp_z", 32'(rsp_z), 32'(last_s == 0));
      acc[0] = 1'b0; acc[1] = 1'b0;
      if (g_ok) begin
        acc[g]    = 1'b1;
        next_free = c + 3;
        pq.push_back('{c + 2, g, alu_ref(int'(rop[g]), int'(ra[g]), int'(rb[g]))});
        prio_m    = 1 - g;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
